onehot_scan_selector: RTL and testbench
=======================================

ONEHOT_SCAN_SELECTOR -- requirements
Module: onehot_scan_selector

Interface
REQ-001 The block SHALL take parameter SEL_W, default 4, as the select index width; output count is N = 2**SEL_W.
REQ-002 The block SHALL take parameter DWELL_W, default 8, as the scan dwell-counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 dis  input  1  disable; while high, outputs forced inactive and all state frozen.
REQ-006 load  input  1  capture sel_in as the current index.
REQ-007 sel_in  input  SEL_W  index to load.
REQ-008 step  input  1  advance the index by one, valid in HOLD only.
REQ-009 scan_start  input  1  enter automatic scan mode.
REQ-010 scan_stop  input  1  leave scan mode and hold the current index.
REQ-011 dwell  input  DWELL_W  scan dwell; the index advances every dwell+1 cycles.
REQ-012 sel_out  output  N  registered one-hot select, bit idx set.
REQ-013 idx  output  SEL_W  registered current index.
REQ-014 active  output  1  high when sel_out is non-zero.
REQ-015 wrap  output  1  one-cycle pulse when idx advances from N-1 to 0.

Function
REQ-016 The block SHALL implement states IDLE, HOLD and SCAN; all outputs are registered, with one-cycle latency from the sampling edge.
REQ-017 In IDLE: sel_out=0, active=0; load moves to HOLD with idx=sel_in; otherwise scan_start moves to SCAN with idx=0 and dwell count=0.
REQ-018 In HOLD: sel_out=1<<idx, active=1; priority is load (idx=sel_in) > scan_start (to SCAN, count=0, idx kept) > step (idx=idx+1 modulo N).
REQ-019 In SCAN: count increments each cycle; when count==dwell, idx=idx+1 modulo N and count=0; dwell=0 advances every cycle.
REQ-020 In SCAN, priority is load (to HOLD, idx=sel_in) > scan_stop (to HOLD, idx kept); step and scan_start are ignored.
REQ-021 wrap SHALL pulse for exactly one cycle, aligned with idx becoming 0, only when idx advances from N-1 by step or by scan; load of 0 SHALL NOT pulse wrap.
REQ-022 While dis=1, the block SHALL register sel_out=0, active=0 and wrap=0, ignore all control inputs, and freeze state, idx and count; on release it resumes where it stopped.
REQ-023 A change of dwell mid-scan SHALL take effect at the next compare; if count>dwell, the next compare SHALL treat it as equal.

Reset
REQ-024 While rst=1: state=IDLE, idx=0, count=0, sel_out=0, active=0 and wrap=0, taking effect at the next edge. rst SHALL override dis and all other inputs, including mid-scan.

Configuration
REQ-025 The macro ONEHOT_SCAN_SELECTOR_SCAN_EN SHALL control scan mode.
REQ-026 When ONEHOT_SCAN_SELECTOR_SCAN_EN is defined, SCAN and the dwell counter SHALL be built.
REQ-027 When ONEHOT_SCAN_SELECTOR_SCAN_EN is undefined, there SHALL be no SCAN state and no counter; scan_start, scan_stop and dwell SHALL remain as ports but be ignored, and wrap SHALL come from step only.

Structure
REQ-028 The shared package onehot_sel_pkg SHALL hold the state enum (IDLE/HOLD/SCAN) and the default SEL_W/DWELL_W constants.
REQ-029 The one-hot conversion SHALL be a combinational sub-module onehot_dec (SEL_W in, 2**SEL_W out), whose result is registered in the parent.

Verification (SEL_W=4)
REQ-030 After rst, load=1 with sel_in=0xA -> next cycle sel_out=16'h0400, idx=0xA, active=1.
REQ-031 HOLD at idx=0xF, step=1 -> sel_out=16'h0001, idx=0, wrap=1 for one cycle only.
REQ-032 HOLD at idx=3, scan_start with dwell=2 -> idx reads 3,3,3,4,4,4,5; scan_stop -> idx stays 5 in HOLD.
REQ-033 SCAN, dis=1 for 5 cycles -> sel_out=0 and idx/count frozen; after release, the remaining dwell completes before the next advance.
REQ-034 SCAN, load=1 (sel_in=0x2) with scan_stop=1 and step=1 in the same cycle -> HOLD, idx=0x2, sel_out=16'h0004.
REQ-035 rst=1 mid-scan at idx=0x7 -> next cycle IDLE, sel_out=0, idx=0, wrap=0.

Source files
------------

// File: rtl/onehot_sel_pkg.sv
// Shared types and default widths for the one-hot scan selector.
package onehot_sel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam int DEF_SEL_W   = 4;
  localparam int DEF_DWELL_W = 8;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder; the parent registers the result.
module onehot_dec #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]         idx,
  output logic [(1<<SEL_W)-1:0]    onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/onehot_scan_selector.sv
// One-hot select generator with hold/step control and optional automatic scan.
// Scan mode and its dwell counter exist only when ONEHOT_SCAN_SELECTOR_SCAN_EN is defined.
module onehot_scan_selector
  import onehot_sel_pkg::*;
#(
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dis,
  input  logic                     load,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     step,
  input  logic                     scan_start,
  input  logic                     scan_stop,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [(1<<SEL_W)-1:0]    sel_out,
  output logic [SEL_W-1:0]         idx,
  output logic                     active,
  output logic                     wrap
);

  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  state_t           state, state_nx;
  logic [SEL_W-1:0] idx_nx;
  logic             wrap_nx;
  logic [N-1:0]     dec_out;

`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
  logic [DWELL_W-1:0] count, count_nx;
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{scan_start, scan_stop, dwell};
`endif

  // Outputs are decoded from the next index so they line up with the registered state.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx    (idx_nx),
    .onehot (dec_out)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wrap_nx  = 1'b0;
`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
    count_nx = count;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          state_nx = HOLD;
          idx_nx   = sel_in;
        end
`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
        else if (scan_start) begin
          state_nx = SCAN;
          idx_nx   = '0;
          count_nx = '0;
        end
`endif
      end
      HOLD: begin
        if (load) begin
          idx_nx = sel_in;
        end
`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
        else if (scan_start) begin
          state_nx = SCAN;
          count_nx = '0;
        end
`endif
        else if (step) begin
          idx_nx  = idx + 1'b1;
          wrap_nx = (idx == IDX_MAX);
        end
      end
`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
      SCAN: begin
        if (load) begin
          state_nx = HOLD;
          idx_nx   = sel_in;
        end else if (scan_stop) begin
          state_nx = HOLD;
        end else if (count >= dwell) begin
          // >= so a dwell lowered below the running count still fires immediately
          idx_nx   = idx + 1'b1;
          count_nx = '0;
          wrap_nx  = (idx == IDX_MAX);
        end else begin
          count_nx = count + 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
      count   <= '0;
`endif
      sel_out <= '0;
      active  <= 1'b0;
      wrap    <= 1'b0;
    end else if (dis) begin
      sel_out <= '0;
      active  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
      count   <= count_nx;
`endif
      sel_out <= (state_nx == IDLE) ? '0 : dec_out;
      active  <= (state_nx != IDLE);
      wrap    <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_onehot_scan_selector.sv
// Directed self-checking bench for onehot_scan_selector (SEL_W=4, DWELL_W=8).
module tb_onehot_scan_selector;

  logic        clk;
  logic        rst;
  logic        dis;
  logic        load;
  logic [3:0]  sel_in;
  logic        step;
  logic        scan_start;
  logic        scan_stop;
  logic [7:0]  dwell;
  logic [15:0] sel_out;
  logic [3:0]  idx;
  logic        active;
  logic        wrap;

  int checks;
  int errors;

  onehot_scan_selector #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dis        (dis),
    .load       (load),
    .sel_in     (sel_in),
    .step       (step),
    .scan_start (scan_start),
    .scan_stop  (scan_stop),
    .dwell      (dwell),
    .sel_out    (sel_out),
    .idx        (idx),
    .active     (active),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of control pulses, then returns them to idle.
  task automatic applyStimulus(input logic l, input logic [3:0] s, input logic st,
                               input logic ss, input logic sp);
    load       = l;
    sel_in     = s;
    step       = st;
    scan_start = ss;
    scan_stop  = sp;
    tick();
    load       = 1'b0;
    step       = 1'b0;
    scan_start = 1'b0;
    scan_stop  = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] e_sel, input logic [3:0] e_idx,
                          input logic e_act, input logic e_wrap);
    checkOutput({tag, ".sel_out"}, 32'(sel_out), 32'(e_sel));
    checkOutput({tag, ".idx"},     32'(idx),     32'(e_idx));
    checkOutput({tag, ".active"},  32'(active),  32'(e_act));
    checkOutput({tag, ".wrap"},    32'(wrap),    32'(e_wrap));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; dis = 1'b0; load = 1'b0; sel_in = 4'h0; step = 1'b0;
    scan_start = 1'b0; scan_stop = 1'b0; dwell = 8'd0;
    tick();
    tick();
    checkAll("reset", 16'h0000, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkAll("idle_step_ignored", 16'h0000, 4'h0, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    checkAll("load_A", 16'h0400, 4'hA, 1'b1, 1'b0);

    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkAll("step_B", 16'h0800, 4'hB, 1'b1, 1'b0);

    applyStimulus(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
    checkAll("load_over_step", 16'h0040, 4'h6, 1'b1, 1'b0);

    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    checkAll("load_F", 16'h8000, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkAll("step_wrap", 16'h0001, 4'h0, 1'b1, 1'b1);
    tick();
    checkAll("wrap_one_cycle", 16'h0001, 4'h0, 1'b1, 1'b0);

    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    checkAll("load_0_no_wrap", 16'h0001, 4'h0, 1'b1, 1'b0);

    // Disable blocks every control and blanks the outputs, then resumes.
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    dis = 1'b1;
    applyStimulus(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    checkAll("dis_hold", 16'h0000, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkAll("dis_hold2", 16'h0000, 4'h9, 1'b0, 1'b0);
    dis = 1'b0;
    tick();
    checkAll("dis_release", 16'h0200, 4'h9, 1'b1, 1'b0);

`ifdef ONEHOT_SCAN_SELECTOR_SCAN_EN
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    dwell = 8'd2;
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("scan_seq0", 32'(idx), 32'h3);
    begin
      logic [3:0] exp_seq [6];
      exp_seq = '{4'h3, 4'h3, 4'h4, 4'h4, 4'h4, 4'h5};
      for (int i = 0; i < 6; i++) begin
        tick();
        checkOutput($sformatf("scan_seq%0d", i + 1), 32'(idx), 32'(exp_seq[i]));
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkAll("scan_stop_hold", 16'h0020, 4'h5, 1'b1, 1'b0);

    dwell = 8'd3;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    dis = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkAll($sformatf("scan_dis%0d", i), 16'h0000, 4'h5, 1'b0, 1'b0);
    end
    dis = 1'b0;
    tick();
    checkAll("scan_resume0", 16'h0020, 4'h5, 1'b1, 1'b0);
    tick();
    checkOutput("scan_resume1", 32'(idx), 32'h5);
    tick();
    checkAll("scan_resume2", 16'h0040, 4'h6, 1'b1, 1'b0);

    dwell = 8'd0;
    tick();
    checkOutput("scan_dwell0", 32'(idx), 32'h7);
    applyStimulus(1'b1, 4'h2, 1'b1, 1'b0, 1'b1);
    checkAll("scan_load_prio", 16'h0004, 4'h2, 1'b1, 1'b0);
    tick();
    checkOutput("scan_load_held", 32'(idx), 32'h2);

    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    checkAll("scan_start_prio", 16'h8000, 4'hF, 1'b1, 1'b0);
    tick();
    checkAll("scan_wrap", 16'h0001, 4'h0, 1'b1, 1'b1);
    tick();
    checkAll("scan_after_wrap", 16'h0002, 4'h1, 1'b1, 1'b0);

    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    dwell = 8'd5;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("scan_at_7", 32'(idx), 32'h7);
    rst = 1'b1;
    dis = 1'b1;
    tick();
    checkAll("rst_mid_scan", 16'h0000, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    dis = 1'b0;
    tick();
    checkAll("rst_stays_idle", 16'h0000, 4'h0, 1'b0, 1'b0);

    dwell = 8'd1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkAll("idle_scan_start", 16'h0001, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("idle_scan_dw1a", 32'(idx), 32'h0);
    tick();
    checkOutput("idle_scan_dw1b", 32'(idx), 32'h1);
    dwell = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("dwell_long%0d", i), 32'(idx), 32'h1);
    end
    dwell = 8'd1;
    tick();
    checkOutput("dwell_shrunk", 32'(idx), 32'h2);
`else
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    checkAll("scan_start_ignored", 16'h0400, 4'hA, 1'b1, 1'b0);
    tick();
    checkOutput("no_scan_advance", 32'(idx), 32'hA);
    rst = 1'b1;
    dis = 1'b1;
    tick();
    checkAll("rst_over_dis", 16'h0000, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    dis = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkAll("idle_scan_ignored", 16'h0000, 4'h0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
